// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmitter.
package uart_pkg;
    localparam int DATA_BITS = 8;
    localparam int CLKS_PER_BIT_DEF = 16;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} tx_state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period divider; tick pulses on the last clock of each bit.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    logic [W-1:0] cnt;
    assign tick = cnt == W'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= (clr || tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter, level-triggered by tx_en.
// Defining UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       fpga_clk,
    input  logic       nrst,
    input  logic       tx_en,
    input  logic [7:0] din,
    output logic       sout
);
    tx_state_t state;
    logic [2:0] idx;
    logic [DATA_BITS-1:0] shreg;
    logic tick;
    // Divider is held at zero while idle so a new frame starts on a clean bit boundary.
    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
        .clk  (fpga_clk),
        .rst_n(nrst),
        .clr  (state == IDLE),
        .tick (tick)
    );
    always_ff @(posedge fpga_clk or negedge nrst)
        if (!nrst) begin
            state <= IDLE;
            sout  <= 1'b1;
            idx   <= '0;
            shreg <= '0;
        end else begin
            case (state)
                IDLE: if (tx_en) begin
                    shreg <= din;
                    sout  <= 1'b0;
                    state <= START;
                end
                START: if (tick) begin
                    state <= DATA;
                    idx   <= '0;
                    sout  <= shreg[0];
                end
                DATA: if (tick) begin
                    if (idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state <= PARITY;
                        sout  <= ^shreg;
`else
                        state <= STOP;
                        sout  <= 1'b1;
`endif
                    end else begin
                        idx  <= idx + 3'd1;
                        sout <= shreg[idx + 3'd1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (tick) begin
                    state <= STOP;
                    sout  <= 1'b1;
                end
`endif
                STOP: if (tick) begin
                    if (tx_en) begin
                        shreg <= din;
                        sout  <= 1'b0;
                        state <= START;
                    end else state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    sout  <= 1'b1;
                end
            endcase
        end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: frame-level reference model plus table-driven and random frames.
module tb_uart_tx;
    localparam int N = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FLEN = NB * N;

    logic fpga_clk = 1'b0, nrst = 1'b0, tx_en = 1'b0, sout;
    logic [7:0] din = 8'h00;
    int tests = 0, fails = 0;

    uart_tx #(.CLKS_PER_BIT(N)) dut (
        .fpga_clk(fpga_clk), .nrst(nrst), .tx_en(tx_en), .din(din), .sout(sout)
    );

    always #5 fpga_clk = ~fpga_clk;

    // Reference: a frame is just an array of bits, each lasting N clocks.
    bit m_busy = 0;
    int m_pos = 0;
    logic [10:0] m_frame = '1;

    function automatic logic [10:0] make_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {2'b11, b, 1'b0};
`endif
    endfunction

    always @(posedge fpga_clk or negedge nrst) begin
        if (!nrst) begin
            m_busy = 0;
            m_pos = 0;
        end else if (!m_busy) begin
            if (tx_en) begin
                m_busy = 1;
                m_pos = 0;
                m_frame = make_frame(din);
            end
        end else begin
            m_pos++;
            if (m_pos == FLEN) begin
                if (tx_en) begin
                    m_pos = 0;
                    m_frame = make_frame(din);
                end else m_busy = 0;
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: sout=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge fpga_clk)
        if (fails < 40) chk("model", sout, m_busy ? m_frame[m_pos / N] : 1'b1);

    typedef struct {
        logic [7:0] din;
        logic [7:0] order;
        logic       par;
        logic       chg;
    } vec_t;
    vec_t tbl[7];

    task automatic send_check(input vec_t v);
        logic e;
        @(negedge fpga_clk);
        din = v.din;
        tx_en = 1'b1;
        @(negedge fpga_clk);
        tx_en = 1'b0;
        for (int k = 0; k < FLEN; k++) begin
            if (k % N == N / 2) begin
                int b = k / N;
                e = (b == 0) ? 1'b0 : (b <= 8) ? v.order[8 - b] :
`ifdef UART_TX_PARITY_EN
                    (b == 9) ? v.par :
`endif
                    1'b1;
                chk("table_bit", sout, e);
            end
            if (k == 3 * N && v.chg) din = ~v.din;
            @(negedge fpga_clk);
        end
        chk("table_idle", sout, 1'b1);
        repeat (3) @(negedge fpga_clk);
    endtask

    initial begin
        tbl[0] = '{8'hAA, 8'h55, 1'b0, 1'b0};
        tbl[1] = '{8'h46, 8'h62, 1'b1, 1'b0};
        tbl[2] = '{8'h01, 8'h80, 1'b1, 1'b0};
        tbl[3] = '{8'hFF, 8'hFF, 1'b0, 1'b0};
        tbl[4] = '{8'h00, 8'h00, 1'b0, 1'b1};
        tbl[5] = '{8'h3C, 8'h3C, 1'b0, 1'b1};
        tbl[6] = '{8'h81, 8'h81, 1'b0, 1'b0};

        // reset holds the line idle
        repeat (5) begin
            @(negedge fpga_clk);
            chk("reset_idle", sout, 1'b1);
        end
        nrst = 1'b1;
        repeat (20) @(negedge fpga_clk);
        chk("idle_no_frame", sout, 1'b1);

        // single 0xAA frame, tx_en raised 7 ns after a falling edge
        din = 8'hAA;
        #7 tx_en = 1'b1;
        @(posedge fpga_clk);
        #1 chk("start_latency", sout, 1'b0);
        @(negedge fpga_clk);
        tx_en = 1'b0;
        repeat (FLEN + 5) @(negedge fpga_clk);

        foreach (tbl[i]) send_check(tbl[i]);

        // back-to-back frames, then a 0x46 frame queued during the last one
        @(negedge fpga_clk);
        din = 8'hAA;
        tx_en = 1'b1;
        repeat (250) @(negedge fpga_clk);
        tx_en = 1'b0;
        repeat (5) @(negedge fpga_clk);
        din = 8'h46;
        tx_en = 1'b1;
        repeat (100) @(negedge fpga_clk);
        tx_en = 1'b0;
        repeat (2 * FLEN) @(negedge fpga_clk);
        chk("after_b2b_idle", sout, 1'b1);

        // asynchronous reset mid-DATA aborts the frame at once
        din = 8'h00;
        tx_en = 1'b1;
        @(negedge fpga_clk);
        tx_en = 1'b0;
        repeat (4 * N + 3) @(negedge fpga_clk);
        chk("mid_data_low", sout, 1'b0);
        #2 nrst = 1'b0;
        #1 chk("abort_async", sout, 1'b1);
        // tx_en during reset is ignored until release
        tx_en = 1'b1;
        repeat (3) begin
            @(negedge fpga_clk);
            chk("tx_en_in_reset", sout, 1'b1);
        end
        din = 8'h46;
        nrst = 1'b1;
        @(posedge fpga_clk);
        #1 chk("start_after_release", sout, 1'b0);
        @(negedge fpga_clk);
        tx_en = 1'b0;
        repeat (FLEN + 5) @(negedge fpga_clk);
        send_check(tbl[1]);

        // random bursts with din churning every cycle
        for (int r = 0; r < 20; r++) begin
            int hold = $urandom_range(1, 400);
            repeat ($urandom_range(0, 3)) @(negedge fpga_clk);
            tx_en = 1'b1;
            for (int c = 0; c < hold; c++) begin
                din = 8'($urandom);
                @(negedge fpga_clk);
            end
            tx_en = 1'b0;
            repeat ($urandom_range(0, FLEN + 20)) begin
                din = 8'($urandom);
                @(negedge fpga_clk);
            end
        end
        repeat (FLEN + 5) @(negedge fpga_clk);
        chk("final_idle", sout, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART serial transmitter: one start bit (0), 8 data bits LSB first, one stop bit (1).
- Sits between a parallel byte producer and the FPGA's serial TX pin.
- Bit timing is derived from the system clock by a fixed clocks-per-bit divider.
- Transmission is level-triggered by tx_en; back-to-back frames are sent while tx_en stays high.

Parameters:
- CLKS_PER_BIT, 16, system clocks per serial bit; legal range ≥2. A 100 MHz clock gives 6.25 Mbaud.
- DATA_BITS, 8, payload width; fixed at 8 in this block, taken from the package.

Ports:
- fpga_clk  in   1  system clock, rising-edge active.
- nrst      in   1  asynchronous active-low reset.
- tx_en     in   1  transmit request, level-sensitive.
- din       in   8  byte to transmit; sampled at frame start only.
- sout      out  1  serial output; idle/mark = 1.

Behaviour:
- One clock, fpga_clk. Reset nrst is asynchronous and active-low.
- Reset:
  - sout = 1; state = IDLE; bit counter = 0; clock divider = 0; shift register = 0.
  - Reset asserted mid-frame aborts the frame immediately; sout returns to 1 asynchronously.
- sout is driven directly from a flop; no combinational path from inputs to sout.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - sout = 1.
  - On a rising edge with tx_en = 1: latch din into the shift register, clear the divider, go to START.
  - sout goes to 0 from that same edge, giving 1-cycle latency from tx_en sampled to the start-bit edge.
- START:
  - sout = 0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - sout = shift_reg[index], LSB first.
  - Each bit is held CLKS_PER_BIT cycles.
  - After bit 7, go to STOP.
- STOP:
  - sout = 1 for exactly CLKS_PER_BIT cycles.
  - At its end, if tx_en = 1: latch the current din and go straight to START. No idle gap; frame period is exactly 10×CLKS_PER_BIT cycles.
  - Otherwise go to IDLE.
- Divider: counts 0..CLKS_PER_BIT-1, wraps, and advances the FSM on the terminal count. Width is $clog2(CLKS_PER_BIT).
- Boundary conditions:
  - din changes during a frame are ignored; the latched copy is sent.
  - tx_en deasserted mid-frame: the current frame completes normally; no new frame starts.
  - tx_en asserted during reset: ignored until nrst deasserts. The first sampling edge after release may start a frame.
  - tx_en pulsed for a single cycle while IDLE: one complete frame is sent.
  - There is no busy output. The producer detects frame boundaries by protocol timing: frames start only from IDLE or at STOP end.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even parity bit (XOR of the 8 latched data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes 11×CLKS_PER_BIT.
- When undefined: plain 8N1 as above; no PARITY state or logic is present.

Decomposition:
- Package uart_pkg:
  - state enum typedef tx_state_t {IDLE, START, DATA, STOP, PARITY}; PARITY is used only under the macro.
  - localparam DATA_BITS = 8.
  - Default CLKS_PER_BIT constant.
- Sub-module uart_baud_tick:
  - Parameterized CLKS_PER_BIT counter with a clear input and a one-cycle tick output on terminal count.
  - uart_tx instantiates it once. The FSM, shift register and sout flop remain in uart_tx.

Test Plan:
- Reset: hold nrst = 0 with tx_en = 0 → sout = 1 throughout; after release with tx_en = 0, sout stays 1 and no frame starts.
- Single frame, din = 0xAA, tx_en raised 7 ns after reset release:
  - bit sequence 0 | 0,1,0,1,0,1,0,1 | 1.
  - Each bit is exactly 16 cycles (160 ns at 100 MHz).
  - Start edge is one clock after tx_en is sampled.
- Back-to-back: tx_en held high 2500 ns with din = 0xAA → consecutive 0xAA frames every 160 cycles with no idle gap. After tx_en falls, the in-flight frame completes, then sout stays 1.
- Second byte: 50 ns after tx_en falls, set din = 0x46 and raise tx_en → bits 0 | 0,1,1,0,0,0,1,0 | 1.
- Mid-frame din change and reset abort:
  - Change din during DATA → transmitted bits unchanged.
  - Assert nrst mid-DATA → sout = 1 immediately; the next frame starts cleanly from IDLE.
- With UART_TX_PARITY_EN, din = 0x46 → parity bit 1 (three ones) after data; frame lasts 176 cycles.
